// File: rtl/ppm_seq_pkg.sv
`default_nettype none
//==============================================================================
// Module      : ppm_seq_pkg
// Description : Shared types and constants for the PPM ADC sequencer.
//               State encoding, channel limits, reset value of the result
//               bank, and a constant clog2 helper for counter sizing.
// Revision    : 1.0 - initial release
//==============================================================================
package ppm_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        START   = 3'd2,
        WAIT    = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } seq_state_t;

    localparam logic [2:0]  NCH4     = 3'd3;
    localparam logic [2:0]  NCH8     = 3'd7;
    localparam logic [11:0] MIDSCALE = 12'h800;

    // Number of bits needed to index 'value' distinct codes (ceil(log2(value)))
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

endpackage : ppm_seq_pkg
`default_nettype wire

// File: rtl/ppm_seq_sync.sv
`default_nettype none
//==============================================================================
// Module      : ppm_seq_sync
// Description : Two-flop synchronizer for the asynchronous ADC end-of-
//               conversion level, followed by a rising-edge detector that
//               produces a single-cycle pulse in the clk domain.
// Revision    : 1.0 - initial release
//==============================================================================
module ppm_seq_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_level,
    output logic rise_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer chain plus one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= async_level;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rise_pulse = r_sync & ~r_prev;

endmodule : ppm_seq_sync
`default_nettype wire

// File: rtl/ppm_adc_sequencer.sv
`default_nettype none
//==============================================================================
// Module      : ppm_adc_sequencer
// Description : Sequences conversions on the external ADC feeding the PPM
//               coder. Drives channel select and start, waits for the
//               synchronized end-of-conversion, and stores one 12-bit result
//               per channel in a register bank read combinationally.
//               Optional feature macro: PPM_SEQ_AVG_EN - two conversions per
//               channel, rounded average stored.
// Revision    : 1.0 - initial release
//==============================================================================
module ppm_adc_sequencer
    import ppm_seq_pkg::*;
#(
    parameter int SETTLE_CYC  = 24,
    parameter int START_CYC   = 12,
    parameter int TIMEOUT_CYC = 1200
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        frame_req,
    input  logic        chan8,
    input  logic        len12,
    input  logic [11:0] adc_data,
    input  logic        adc_ok,
    output logic        start_o,
    output logic [2:0]  sel_o,
    output logic        busy,
    output logic        sweep_done,
    input  logic [2:0]  rd_ch,
    output logic [11:0] rd_data,
    output logic [7:0]  ch_err
);

    // One shared down-counter; it must hold the longest interval (the timeout)
    localparam int            CW          = clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] C_SETTLE_LD = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] C_START_LD  = CW'(START_CYC - 1);
    localparam logic [CW-1:0] C_WAIT_LD   = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] C_CNT_ONE   = CW'(1);

    seq_state_t    r_state;
    seq_state_t    w_next;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_ch;
    logic [2:0]    r_sel;
    logic          r_chan8;
    logic          r_len12;
    logic          r_pending;
    logic [11:0]   r_bank [8];
    logic [7:0]    r_err;

    logic          w_ok_rise;
    logic          w_cnt_zero;
    logic          w_last;
    logic          w_timeout;
    logic          w_done_ch;
    logic          w_advance;
    logic          w_start_sweep;
    logic [11:0]   w_sample;
    logic [11:0]   w_store;

    ppm_seq_sync u_sync (
        .clk         (wb_clk_i),
        .rst         (wb_rst_i),
        .async_level (adc_ok),
        .rise_pulse  (w_ok_rise)
    );

    // 8-bit converters are left-justified into the 12-bit result
    assign w_sample      = r_len12 ? adc_data : {adc_data[7:0], 4'h0};
    assign w_cnt_zero    = (r_cnt == '0);
    assign w_last        = (r_ch == (r_chan8 ? NCH8 : NCH4));
    assign w_timeout     = (r_state == WAIT) && !w_ok_rise && w_cnt_zero;
    assign w_advance     = w_done_ch || w_timeout;
    assign w_start_sweep = (r_state == IDLE) && (frame_req || r_pending);

`ifdef PPM_SEQ_AVG_EN
    logic        r_second;
    logic [11:0] r_s0;

    // Rounded mean of the two conversions, computed in 13 bits to keep the carry
    assign w_store   = 12'(({1'b0, r_s0} + {1'b0, w_sample} + 13'd1) >> 1);
    assign w_done_ch = (r_state == CAPTURE) && r_second;

    // Hold the first conversion and track which of the pair is in flight
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_second <= 1'b0;
            r_s0     <= 12'h000;
        end else if (r_state == CAPTURE) begin
            if (!r_second) begin
                r_s0 <= w_sample;
            end
            r_second <= ~r_second;
        end else if (w_timeout) begin
            r_second <= 1'b0;
        end
    end
`else
    assign w_store   = w_sample;
    assign w_done_ch = (r_state == CAPTURE);
`endif

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; ok_rise wins over a timeout landing in the same cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (frame_req || r_pending) begin
                    w_next = SETTLE;
                end
            end
            SETTLE: begin
                if (w_cnt_zero) begin
                    w_next = START;
                end
            end
            START: begin
                if (w_cnt_zero) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                if (w_ok_rise) begin
                    w_next = CAPTURE;
                end else if (w_cnt_zero) begin
                    w_next = w_last ? DONE : SETTLE;
                end
            end
            CAPTURE: begin
`ifdef PPM_SEQ_AVG_EN
                if (!r_second) begin
                    w_next = START;
                end else
`endif
                begin
                    w_next = w_last ? DONE : SETTLE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        start_o    = (r_state == START);
        sweep_done = (r_state == DONE);
        busy       = (r_state != IDLE);
    end

    // Interval counter: reload on entry to a timed state, otherwise count down
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            case (w_next)
                SETTLE:  r_cnt <= C_SETTLE_LD;
                START:   r_cnt <= C_START_LD;
                WAIT:    r_cnt <= C_WAIT_LD;
                default: r_cnt <= '0;
            endcase
        end else if (!w_cnt_zero) begin
            r_cnt <= r_cnt - C_CNT_ONE;
        end
    end

    // Sweep bookkeeping: mode latch, channel index, select, pending request
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_chan8   <= 1'b0;
            r_len12   <= 1'b0;
            r_ch      <= 3'd0;
            r_sel     <= 3'd0;
            r_pending <= 1'b0;
        end else begin
            if (w_start_sweep) begin
                r_chan8 <= chan8;
                r_len12 <= len12;
                r_ch    <= 3'd0;
                r_sel   <= 3'd0;
            end else if (w_advance && !w_last) begin
                r_ch    <= r_ch + 3'd1;
                r_sel   <= r_ch + 3'd1;
            end

            // Any request seen in IDLE starts a sweep, so pending only collects
            // requests that arrive while a sweep (including DONE) is running
            if (r_state == IDLE) begin
                r_pending <= 1'b0;
            end else if (frame_req) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Result bank and per-channel timeout flags
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < 8; i++) begin
                r_bank[i] <= MIDSCALE;
            end
            r_err <= 8'h00;
        end else if (w_done_ch) begin
            r_bank[r_ch] <= w_store;
            r_err[r_ch]  <= 1'b0;
        end else if (w_timeout) begin
            r_err[r_ch]  <= 1'b1;
        end
    end

    assign sel_o   = r_sel;
    assign rd_data = r_bank[rd_ch];
    assign ch_err  = r_err;

endmodule : ppm_adc_sequencer
`default_nettype wire
